// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: PC field positions, counter init values, entry layout.
package bp_pkg;

  localparam int PC_ALIGN_BITS = 2;
  localparam int DEF_TAG_W     = 8;
  localparam int DEF_PC_W      = 32;
  localparam int DEF_CNT_W     = 2;

  function automatic int idx_lsb();
    return PC_ALIGN_BITS;
  endfunction

  function automatic int tag_lsb(input int idx_w);
    return PC_ALIGN_BITS + idx_w;
  endfunction

  // Weakly-taken is the counter midpoint; weakly-not-taken sits just below it.
  function automatic int ctr_weak_t(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  function automatic int ctr_weak_nt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_PC_W-1:0]  target;
    logic [DEF_CNT_W-1:0] ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-value logic for a saturating up/down direction counter.
module bp_sat_ctr #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] ctr,
  input  logic             inc,
  output logic [CNT_W-1:0] ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (inc) begin
      if (ctr != '1) ctr_nxt = ctr + 1'b1;
    end else begin
      if (ctr != '0) ctr_nxt = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// BTB plus per-entry saturating counters; zero-latency lookup, registered update.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int PC_W    = 32
) (
  input  logic            clk_i,
  input  logic            start_i,
  input  logic            if_valid_i,
  input  logic [PC_W-1:0] if_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i,
  input  logic            upd_mispred_i,
  input  logic            stat_clr_i,
  output logic [31:0]     stat_lookups_o,
  output logic [31:0]     stat_mispred_o
);

  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int IDX_LSB = idx_lsb();
  localparam int TAG_LSB = tag_lsb(IDX_W);
  localparam logic [CNT_W-1:0] CTR_INIT_T  = CNT_W'(ctr_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] CTR_INIT_NT = CNT_W'(ctr_weak_nt(CNT_W));

  // Same field layout as bp_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CNT_W-1:0] ctr;
  } entry_t;

  entry_t table_q [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  entry_t           if_entry;

  assign if_idx   = if_pc_i[IDX_LSB +: IDX_W];
  assign if_tag   = if_pc_i[TAG_LSB +: TAG_W];
  assign if_entry = table_q[if_idx];

  assign pred_hit_o    = if_valid_i & if_entry.valid & (if_entry.tag == if_tag);
  assign pred_taken_o  = pred_hit_o & if_entry.ctr[CNT_W-1];
  assign pred_target_o = pred_taken_o ? if_entry.target : if_pc_i + PC_W'(4);

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  entry_t           upd_entry;
  logic             upd_hit;
  logic [CNT_W-1:0] upd_ctr_nxt;

  assign upd_idx   = upd_pc_i[IDX_LSB +: IDX_W];
  assign upd_tag   = upd_pc_i[TAG_LSB +: TAG_W];
  assign upd_entry = table_q[upd_idx];
  assign upd_hit   = upd_entry.valid & (upd_entry.tag == upd_tag);

  bp_sat_ctr #(.CNT_W(CNT_W)) u_upd_ctr (
    .ctr     (upd_entry.ctr),
    .inc     (upd_taken_i),
    .ctr_nxt (upd_ctr_nxt)
  );

  // A hit trains the existing entry; a taken miss replaces whatever lives at that index.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT_NT};
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        table_q[upd_idx].ctr <= upd_ctr_nxt;
        if (upd_taken_i) table_q[upd_idx].target <= upd_target_i;
      end else if (upd_taken_i) begin
        table_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target_i, ctr: CTR_INIT_T};
      end
    end
  end

  logic unused_pc;
  assign unused_pc = ^{if_pc_i, upd_pc_i};

`ifdef BP_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] mispred_q;

  // Clear wins over counting; both counters stick at all-ones.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else if (stat_clr_i) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (if_valid_i && (lookups_q != '1)) lookups_q <= lookups_q + 32'd1;
      if (upd_valid_i && upd_mispred_i && (mispred_q != '1)) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_lookups_o = lookups_q;
  assign stat_mispred_o = mispred_q;
`else
  logic unused_stat;
  assign unused_stat    = ^{stat_clr_i, upd_mispred_i};
  assign stat_lookups_o = '0;
  assign stat_mispred_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with an array-based reference model checked every cycle.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        start_i = 1'b1;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_mispred_i = 1'b0;
  logic        stat_clr_i = 1'b0;
  logic [31:0] stat_lookups_o;
  logic [31:0] stat_mispred_o;

  branch_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_W(2), .PC_W(32)) dut (
    .clk_i          (clk_i),
    .start_i        (start_i),
    .if_valid_i     (if_valid_i),
    .if_pc_i        (if_pc_i),
    .pred_hit_o     (pred_hit_o),
    .pred_taken_o   (pred_taken_o),
    .pred_target_o  (pred_target_o),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_target_i   (upd_target_i),
    .upd_mispred_i  (upd_mispred_i),
    .stat_clr_i     (stat_clr_i),
    .stat_lookups_o (stat_lookups_o),
    .stat_mispred_o (stat_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  int err_count   = 0;
  int check_count = 0;
  bit cmp_en      = 1'b0;

  // Reference model: a plain 16-entry table indexed by word address modulo 16.
  bit          m_valid  [16];
  logic [7:0]  m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  logic [31:0] m_lookups;
  logic [31:0] m_mispred;

  function automatic int pc_index(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic logic [7:0] pc_tag(input logic [31:0] pc);
    return 8'((pc >> 6) & 32'hFF);
  endfunction

  function bit model_hit(input logic [31:0] pc);
    return m_valid[pc_index(pc)] && (m_tag[pc_index(pc)] == pc_tag(pc));
  endfunction

  always @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i]  <= 1'b0;
        m_tag[i]    <= '0;
        m_target[i] <= '0;
        m_ctr[i]    <= 1;
      end
      m_lookups <= '0;
      m_mispred <= '0;
    end else begin
      if (upd_valid_i) begin
        if (model_hit(upd_pc_i)) begin
          if (upd_taken_i) begin
            m_ctr[pc_index(upd_pc_i)]    <= (m_ctr[pc_index(upd_pc_i)] < 3) ? m_ctr[pc_index(upd_pc_i)] + 1 : 3;
            m_target[pc_index(upd_pc_i)] <= upd_target_i;
          end else begin
            m_ctr[pc_index(upd_pc_i)] <= (m_ctr[pc_index(upd_pc_i)] > 0) ? m_ctr[pc_index(upd_pc_i)] - 1 : 0;
          end
        end else if (upd_taken_i) begin
          m_valid[pc_index(upd_pc_i)]  <= 1'b1;
          m_tag[pc_index(upd_pc_i)]    <= pc_tag(upd_pc_i);
          m_target[pc_index(upd_pc_i)] <= upd_target_i;
          m_ctr[pc_index(upd_pc_i)]    <= 2;
        end
      end
`ifdef BP_STATS_EN
      if (stat_clr_i) begin
        m_lookups <= '0;
        m_mispred <= '0;
      end else begin
        if (if_valid_i && m_lookups != 32'hFFFF_FFFF) m_lookups <= m_lookups + 1;
        if (upd_valid_i && upd_mispred_i && m_mispred != 32'hFFFF_FFFF) m_mispred <= m_mispred + 1;
      end
`endif
    end
  end

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      bit          e_hit;
      bit          e_taken;
      logic [31:0] e_target;
      e_hit    = if_valid_i && model_hit(if_pc_i);
      e_taken  = e_hit && (m_ctr[pc_index(if_pc_i)] >= 2);
      e_target = e_taken ? m_target[pc_index(if_pc_i)] : if_pc_i + 32'd4;
      check_value("model_hit",    {31'd0, pred_hit_o},   {31'd0, e_hit});
      check_value("model_taken",  {31'd0, pred_taken_o}, {31'd0, e_taken});
      check_value("model_target", pred_target_o, e_target);
      check_value("model_lookups", stat_lookups_o, m_lookups);
      check_value("model_mispred", stat_mispred_o, m_mispred);
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input bit ifv, input logic [31:0] ipc, input bit uv,
                                input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                                input bit mis, input bit clr);
    if_valid_i    = ifv;
    if_pc_i       = ipc;
    upd_valid_i   = uv;
    upd_pc_i      = upc;
    upd_taken_i   = ut;
    upd_target_i  = utgt;
    upd_mispred_i = mis;
    stat_clr_i    = clr;
  endtask

  task automatic lookup_only(input logic [31:0] pc);
    apply_stimulus(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_output(input string name, input bit hit, input bit taken, input logic [31:0] target);
    @(negedge clk_i);
    check_value({name, "_hit"},    {31'd0, pred_hit_o},   {31'd0, hit});
    check_value({name, "_taken"},  {31'd0, pred_taken_o}, {31'd0, taken});
    check_value({name, "_target"}, pred_target_o, target);
  endtask

  task automatic check_stats(input string name, input logic [31:0] lk, input logic [31:0] mp);
    @(negedge clk_i);
    check_value({name, "_lookups"}, stat_lookups_o, lk);
    check_value({name, "_mispred"}, stat_mispred_o, mp);
  endtask

  task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    next_cycle();
    apply_stimulus(1'b0, '0, 1'b1, pc, taken, tgt, 1'b0, 1'b0);
  endtask

  initial begin
    #1;
    start_i = 1'b0;
    cmp_en  = 1'b1;
    lookup_only(32'h40);
    repeat (2) @(posedge clk_i);
    check_output("reset_lookup", 1'b0, 1'b0, 32'h44);
    next_cycle();
    start_i = 1'b1;

    // First taken update allocates weakly taken; same-cycle lookup still sees the old table.
    apply_stimulus(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 1'b0);
    check_output("alloc_same_cycle", 1'b0, 1'b0, 32'h44);
    next_cycle();
    lookup_only(32'h40);
    check_output("alloc_next", 1'b1, 1'b1, 32'h20);
    next_cycle();
    apply_stimulus(1'b0, 32'h40, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    check_output("if_valid_low", 1'b0, 1'b0, 32'h44);

    train(32'h40, 1'b0, '0);
    next_cycle();
    lookup_only(32'h40);
    check_output("ctr1", 1'b1, 1'b0, 32'h44);
    train(32'h40, 1'b0, '0);
    next_cycle();
    lookup_only(32'h40);
    check_output("ctr0", 1'b1, 1'b0, 32'h44);
    train(32'h40, 1'b1, 32'h20);
    next_cycle();
    lookup_only(32'h40);
    check_output("hyst_ctr1", 1'b1, 1'b0, 32'h44);

    train(32'h40, 1'b0, '0);
    for (int i = 0; i < 5; i++) train(32'h40, 1'b1, 32'h20);
    next_cycle();
    lookup_only(32'h40);
    check_output("sat5", 1'b1, 1'b1, 32'h20);
    train(32'h40, 1'b1, 32'h20);
    train(32'h40, 1'b0, '0);
    next_cycle();
    lookup_only(32'h40);
    check_output("sat_dec_once", 1'b1, 1'b1, 32'h20);
    train(32'h40, 1'b0, '0);
    next_cycle();
    lookup_only(32'h40);
    check_output("sat_dec_twice", 1'b1, 1'b0, 32'h44);

    next_cycle();
    lookup_only(32'h440);
    check_output("alias_miss", 1'b0, 1'b0, 32'h444);
    train(32'h440, 1'b1, 32'h100);
    next_cycle();
    lookup_only(32'h440);
    check_output("alias_hit", 1'b1, 1'b1, 32'h100);
    next_cycle();
    lookup_only(32'h40);
    check_output("alias_evicted", 1'b0, 1'b0, 32'h44);

    next_cycle();
    apply_stimulus(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 1'b0);
    check_output("same_cycle_miss", 1'b0, 1'b0, 32'h84);
    next_cycle();
    lookup_only(32'h80);
    check_output("same_cycle_next", 1'b1, 1'b1, 32'h300);
    train(32'hC0, 1'b0, '0);
    next_cycle();
    lookup_only(32'hC0);
    check_output("nt_no_alloc", 1'b0, 1'b0, 32'hC4);
    next_cycle();
    lookup_only(32'h80);
    check_output("nt_no_alloc_keep", 1'b1, 1'b1, 32'h300);

    // Reset arriving with an update in flight drops the update and empties the table.
    next_cycle();
    start_i = 1'b0;
    apply_stimulus(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0, 1'b0);
    check_output("midrun_reset", 1'b0, 1'b0, 32'h84);
    next_cycle();
    lookup_only(32'h40);
    next_cycle();
    start_i = 1'b1;
    check_output("midrun_reset_40", 1'b0, 1'b0, 32'h44);
    next_cycle();
    lookup_only(32'h80);
    check_output("after_reset_80", 1'b0, 1'b0, 32'h84);

    next_cycle();
    apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      apply_stimulus(1'b1, 32'h40 + 32'(4 * i), (i < 3), 32'h1000, 1'b0, '0, (i < 3), 1'b0);
    end
    next_cycle();
    apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
`ifdef BP_STATS_EN
    check_stats("stats_count", 32'd10, 32'd3);
`else
    check_stats("stats_count", 32'd0, 32'd0);
`endif
    next_cycle();
    apply_stimulus(1'b1, 32'h40, 1'b1, 32'h1000, 1'b0, '0, 1'b1, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    check_stats("stats_clear", 32'd0, 32'd0);

    next_cycle();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
